// File: rtl/barrett_mu_precomp.sv
// Barrett constant precomputation: finds the bit length k of a modulus m and
// derives mu = floor(2^(2k)/m) by restoring division, one quotient bit per cycle.

package multiplier_pkg;
    parameter int DATA_LENGTH = 64;
endpackage

module barrett_mu_precomp #(
    parameter int DATA_LENGTH = multiplier_pkg::DATA_LENGTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [DATA_LENGTH-1:0] m_i,
    output logic                   busy_o,
    output logic                   valid_o,
    output logic                   err_o,
    output logic [DATA_LENGTH-1:0] m_o,
    output logic [DATA_LENGTH-1:0] m_bl_o,
    output logic [DATA_LENGTH-1:0] mu_o
);

    localparam int KW = $clog2(DATA_LENGTH + 1);
    localparam int CW = KW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BITLEN = 2'd1,
        S_DIVIDE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nx;

    logic [DATA_LENGTH-1:0] r_m;
    logic [KW-1:0]          r_k;
    logic [CW-1:0]          r_cnt;
    logic [DATA_LENGTH:0]   r_rem;
    logic [DATA_LENGTH-1:0] r_quo;
    logic [DATA_LENGTH-1:0] r_mu;
    logic [KW-1:0]          r_mbl;
    logic                   r_err;

    logic [KW-1:0]          w_k;
    logic                   w_legal;
    logic                   w_first_step;
    logic [DATA_LENGTH:0]   w_rem_sh;
    logic [DATA_LENGTH:0]   w_m_ext;
    logic                   w_ge;
    logic [DATA_LENGTH:0]   w_rem_nx;
    logic [DATA_LENGTH-1:0] w_quo_nx;

    // Priority encoder: the highest set bit wins, giving its index + 1.
    function automatic logic [KW-1:0] f_bitlen(input logic [DATA_LENGTH-1:0] v);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < DATA_LENGTH; i++) begin
            if (v[i]) begin
                k = KW'(i + 1);
            end
        end
        return k;
    endfunction

    assign w_k     = f_bitlen(r_m);
    assign w_legal = (w_k != '0) && (w_k <= KW'(DATA_LENGTH - 2));

    // The dividend 2^(2k) contributes its single 1 bit on the very first step.
    assign w_first_step = (r_cnt == {r_k, 1'b0});
    assign w_rem_sh     = (r_rem << 1) | {{DATA_LENGTH{1'b0}}, w_first_step};
    assign w_m_ext      = {1'b0, r_m};
    assign w_ge         = (w_rem_sh >= w_m_ext);
    assign w_rem_nx     = w_ge ? (w_rem_sh - w_m_ext) : w_rem_sh;
    assign w_quo_nx     = (r_quo << 1) | {{(DATA_LENGTH-1){1'b0}}, w_ge};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:   w_state_nx = start_i ? S_BITLEN : S_IDLE;
            S_BITLEN: w_state_nx = w_legal ? S_DIVIDE : S_DONE;
            S_DIVIDE: w_state_nx = (r_cnt == '0) ? S_DONE : S_DIVIDE;
            S_DONE:   w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o  = 1'b0;
        valid_o = 1'b0;
        case (r_state)
            S_IDLE:   busy_o = 1'b0;
            S_BITLEN: busy_o = 1'b1;
            S_DIVIDE: busy_o = 1'b1;
            S_DONE: begin
                busy_o  = 1'b1;
                valid_o = 1'b1;
            end
            default:  busy_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_m   <= '0;
            r_k   <= '0;
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_mu  <= '0;
            r_mbl <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_m   <= m_i;
                        r_mu  <= '0;
                        r_mbl <= '0;
                        r_err <= 1'b0;
                    end
                end
                S_BITLEN: begin
                    r_k <= w_k;
                    if (w_legal) begin
                        r_cnt <= {w_k, 1'b0};
                        r_rem <= '0;
                        r_quo <= '0;
                    end else begin
                        r_err <= 1'b1;
                        r_mu  <= '0;
                        r_mbl <= '0;
                    end
                end
                S_DIVIDE: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    if (r_cnt == '0) begin
                        r_mu  <= w_quo_nx;
                        r_mbl <= r_k;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign err_o  = r_err;
    assign m_o    = r_m;
    assign m_bl_o = {{(DATA_LENGTH-KW){1'b0}}, r_mbl};
    assign mu_o   = r_mu;

endmodule
